wb_accel_stream_slave: RTL and testbench

Wishbone classic slave front-end for tile accelerators. It is the responder to the network adapter's Wishbone master port. Memory-mapped writes are turned into a valid/ready input stream toward the accelerator core, and the core's output stream is buffered for reads. It also provides start/done control and status, so accelerators implement only streaming datapaths.

---
 rtl/wb_accel_pkg.sv | 27 ++
 rtl/wb_stream_fifo.sv | 51 +++++
 rtl/wb_accel_stream_slave.sv | 178 +++++++++++++++++
 tb/tb_wb_accel_stream_slave.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_accel_pkg.sv
// Shared register map, STATUS/CTRL bit positions and control-state encoding
// for the Wishbone accelerator stream slave.
package wb_accel_pkg;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_DATA_IN  = 2'd2;
    localparam logic [1:0] REG_DATA_OUT = 2'd3;

    localparam int ST_BUSY      = 0;
    localparam int ST_DONE      = 1;
    localparam int ST_IN_FULL   = 2;
    localparam int ST_OUT_EMPTY = 3;
    localparam int ST_IN_COUNT  = 8;
    localparam int ST_OUT_COUNT = 16;

    localparam int CTRL_START  = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int CTRL_IRQ_EN = 2;

    typedef enum logic [1:0] {
        CTL_IDLE = 2'd0,
        CTL_BUSY = 2'd1,
        CTL_DONE = 2'd2
    } ctl_state_t;

endpackage

// File: rtl/wb_stream_fifo.sv
// First-word-fall-through FIFO with synchronous clear; callers never push
// when full or pop when empty.
module wb_stream_fifo #(
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [31:0]      push_data,
    input  logic             pop,
    output logic [31:0]      head,
    output logic [CNT_W-1:0] count
);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Clear outranks any push or pop on the same edge; pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr)
            mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_accel_stream_slave.sv
// Wishbone classic slave bridging register accesses to accelerator streams.
// Optional irq output and CTRL irq-enable bit when ACCEL_SLAVE_IRQ_EN is defined.
module wb_accel_stream_slave
    import wb_accel_pkg::*;
#(
    parameter  int FIFO_DEPTH = 16,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic [31:0] acc_in_data,
    output logic        acc_in_valid,
    input  logic        acc_in_ready,
    input  logic [31:0] acc_out_data,
    input  logic        acc_out_valid,
    output logic        acc_out_ready,
    output logic        acc_start,
    input  logic        acc_done
`ifdef ACCEL_SLAVE_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic [1:0]       reg_sel;
    logic             req;
    logic             bad;
    logic             wr_ok;
    logic             rd_ok;
    logic             ctrl_wr;
    logic             start_req;
    logic             clear_req;
    logic             in_push;
    logic             in_pop;
    logic             out_push;
    logic             out_pop;
    logic [CNT_W-1:0] in_count;
    logic [CNT_W-1:0] out_count;
    logic [31:0]      out_head;
    logic             in_full;
    logic             out_empty;
    logic             busy;
    logic             done;
    logic             irq_en;
    logic [31:0]      status_word;
    logic [31:0]      rd_data;
    ctl_state_t       state;
    logic             unused_ok;

    assign unused_ok = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0]};
    assign wb_rty_o  = 1'b0;
    assign reg_sel   = wb_adr_i[3:2];
    assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign in_full   = (in_count == CNT_W'(FIFO_DEPTH));
    assign out_empty = (out_count == '0);
    assign busy      = (state == CTL_BUSY);
    assign done      = (state == CTL_DONE);

    // Illegal direction or an overflowing/underflowing stream access errors out.
    always_comb begin
        bad = 1'b0;
        case (reg_sel)
            REG_STATUS:   bad = wb_we_i;
            REG_DATA_IN:  bad = !wb_we_i || in_full;
            REG_DATA_OUT: bad = wb_we_i || out_empty;
            default:      bad = 1'b0;
        endcase
    end

    assign wr_ok     = req & ~bad & wb_we_i;
    assign rd_ok     = req & ~bad & ~wb_we_i;
    assign ctrl_wr   = wr_ok & (reg_sel == REG_CTRL);
    assign start_req = ctrl_wr & wb_dat_i[CTRL_START];
    assign clear_req = ctrl_wr & wb_dat_i[CTRL_CLEAR];
    assign in_push   = wr_ok & (reg_sel == REG_DATA_IN);
    assign in_pop    = acc_in_valid & acc_in_ready;
    assign out_push  = acc_out_valid & acc_out_ready;
    assign out_pop   = rd_ok & (reg_sel == REG_DATA_OUT);

    assign acc_in_valid  = (in_count != '0);
    assign acc_out_ready = (out_count != CNT_W'(FIFO_DEPTH));

    wb_stream_fifo #(.DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (clear_req),
        .push      (in_push),
        .push_data (wb_dat_i),
        .pop       (in_pop),
        .head      (acc_in_data),
        .count     (in_count)
    );

    wb_stream_fifo #(.DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (clear_req),
        .push      (out_push),
        .push_data (acc_out_data),
        .pop       (out_pop),
        .head      (out_head),
        .count     (out_count)
    );

    always_comb begin
        status_word               = '0;
        status_word[ST_BUSY]      = busy;
        status_word[ST_DONE]      = done;
        status_word[ST_IN_FULL]   = in_full;
        status_word[ST_OUT_EMPTY] = out_empty;
        status_word[ST_IN_COUNT  +: 8] = 8'(in_count);
        status_word[ST_OUT_COUNT +: 8] = 8'(out_count);
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_CTRL:     rd_data[CTRL_IRQ_EN] = irq_en;
            REG_STATUS:   rd_data = status_word;
            REG_DATA_OUT: rd_data = out_head;
            default:      rd_data = '0;
        endcase
    end

    // Exactly one of ack/err follows every accepted request; data is zero on error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req & ~bad;
            wb_err_o <= req & bad;
            if (req)
                wb_dat_o <= (bad || wb_we_i) ? 32'd0 : rd_data;
        end
    end

    // A start always wins, even against a coincident done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CTL_IDLE;
            acc_start <= 1'b0;
        end else begin
            acc_start <= start_req;
            if (start_req)
                state <= CTL_BUSY;
            else if (acc_done && state == CTL_BUSY)
                state <= CTL_DONE;
        end
    end

`ifdef ACCEL_SLAVE_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (ctrl_wr)
                irq_en <= wb_dat_i[CTRL_IRQ_EN];
            irq <= done & irq_en;
        end
    end
`else
    assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_wb_accel_stream_slave.sv
// Self-checking bench: queue-based reference model plus directed and random traffic.
// Honours ACCEL_SLAVE_IRQ_EN when the design is built with it.
module tb_wb_accel_stream_slave;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic [31:0] acc_in_data;
    logic        acc_in_valid;
    logic        acc_in_ready;
    logic [31:0] acc_out_data;
    logic        acc_out_valid;
    logic        acc_out_ready;
    logic        acc_start;
    logic        acc_done;
`ifdef ACCEL_SLAVE_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    wb_accel_stream_slave #(.FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_adr_i      (wb_adr_i),
        .wb_dat_i      (wb_dat_i),
        .wb_sel_i      (wb_sel_i),
        .wb_we_i       (wb_we_i),
        .wb_cyc_i      (wb_cyc_i),
        .wb_stb_i      (wb_stb_i),
        .wb_dat_o      (wb_dat_o),
        .wb_ack_o      (wb_ack_o),
        .wb_err_o      (wb_err_o),
        .wb_rty_o      (wb_rty_o),
        .acc_in_data   (acc_in_data),
        .acc_in_valid  (acc_in_valid),
        .acc_in_ready  (acc_in_ready),
        .acc_out_data  (acc_out_data),
        .acc_out_valid (acc_out_valid),
        .acc_out_ready (acc_out_ready),
        .acc_start     (acc_start),
        .acc_done      (acc_done)
`ifdef ACCEL_SLAVE_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int starts_seen = 0;
    bit checking = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFOs as queues, control as two flags, bus as one-shot flags.
    logic [31:0] in_q[$];
    logic [31:0] out_q[$];
    bit          m_busy = 0, m_done = 0, m_irq_en = 0, m_irq = 0;
    bit          m_ack = 0, m_err = 0, m_rd = 0, m_start = 0;
    logic [31:0] m_dat = '0;

    always @(posedge clk or posedge rst) begin : model_blk
        int          in_n;
        int          out_n;
        int          idx;
        bit          accept;
        bit          bad;
        logic [31:0] rd_val;
        if (rst) begin
            in_q.delete();
            out_q.delete();
            m_busy = 0; m_done = 0; m_irq_en = 0; m_irq = 0;
            m_ack = 0; m_err = 0; m_rd = 0; m_start = 0;
            m_dat = '0;
        end else begin
            in_n   = in_q.size();
            out_n  = out_q.size();
            idx    = int'(wb_adr_i[3:2]);
            accept = wb_cyc_i && wb_stb_i && !m_ack && !m_err;
            bad    = (idx == 1 && wb_we_i) || (idx == 3 && wb_we_i) || (idx == 2 && !wb_we_i)
                  || (idx == 2 && wb_we_i && in_n == DEPTH) || (idx == 3 && !wb_we_i && out_n == 0);
            rd_val = 0;
            if (idx == 1)
                rd_val = m_busy + 2 * m_done + 4 * (in_n == DEPTH) + 8 * (out_n == 0)
                       + in_n * 256 + out_n * 65536;
            else if (idx == 3 && out_n > 0)
                rd_val = out_q[0];
`ifdef ACCEL_SLAVE_IRQ_EN
            else if (idx == 0)
                rd_val = 4 * m_irq_en;
`endif
            m_irq = m_done && m_irq_en;
            m_ack = accept && !bad;
            m_err = accept && bad;
            m_rd  = accept && !bad && !wb_we_i;
            if (accept)
                m_dat = (bad || wb_we_i) ? 32'd0 : rd_val;

            if (acc_in_ready && in_n > 0)
                void'(in_q.pop_front());
            if (accept && !bad && wb_we_i && idx == 2)
                in_q.push_back(wb_dat_i);
            if (accept && !bad && !wb_we_i && idx == 3)
                void'(out_q.pop_front());
            if (acc_out_valid && out_n < DEPTH)
                out_q.push_back(acc_out_data);

            m_start = 0;
            if (accept && wb_we_i && idx == 0) begin
                if (wb_dat_i[0]) begin
                    m_start = 1; m_busy = 1; m_done = 0;
                end
                if (wb_dat_i[1]) begin
                    in_q.delete();
                    out_q.delete();
                end
                m_irq_en = wb_dat_i[2];
            end
            if (!m_start && acc_done && m_busy) begin
                m_busy = 0; m_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check_output("ack", 32'(wb_ack_o), 32'(m_ack));
            check_output("err", 32'(wb_err_o), 32'(m_err));
            check_output("rty", 32'(wb_rty_o), 32'd0);
            check_output("acc_start", 32'(acc_start), 32'(m_start));
            check_output("in_valid", 32'(acc_in_valid), 32'(in_q.size() != 0));
            check_output("out_ready", 32'(acc_out_ready), 32'(out_q.size() != DEPTH));
            if (in_q.size() != 0)
                check_output("in_data", acc_in_data, in_q[0]);
            if (m_err)
                check_output("err_dat", wb_dat_o, 32'd0);
            if (m_ack && m_rd)
                check_output("rd_dat", wb_dat_o, m_dat);
`ifdef ACCEL_SLAVE_IRQ_EN
            check_output("irq", 32'(irq), 32'(m_irq));
`endif
        end
        if (acc_start)
            starts_seen++;
    end

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           output logic [31:0] rdata, output logic got_err);
        bit got = 0;
        @(posedge clk); #2;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb_ack_o || wb_err_o) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL xfer_timeout: got no ack/err, expected one for adr %h", adr);
        end
        rdata   = wb_dat_o;
        got_err = wb_err_o;
        @(posedge clk); #2;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    endtask

    task automatic pulse_done();
        @(posedge clk); #2 acc_done = 1;
        @(posedge clk); #2 acc_done = 0;
    endtask

    task automatic apply_stimulus(input int cycles);
        logic [1:0] idx;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #2;
            acc_in_ready  = ($urandom_range(0, 3) != 0);
            acc_out_valid = 1'($urandom_range(0, 1));
            acc_out_data  = $urandom;
            acc_done      = ($urandom_range(0, 15) == 0);
            if (wb_cyc_i && (wb_ack_o || wb_err_o)) begin
                wb_cyc_i = 0; wb_stb_i = 0;
            end else if (!wb_cyc_i && $urandom_range(0, 2) == 0) begin
                idx      = 2'($urandom_range(0, 3));
                wb_adr_i = ($urandom & 32'hFFFF_FFF0) | {28'd0, idx, 2'($urandom_range(0, 3))};
                wb_we_i  = 1'($urandom_range(0, 1));
                wb_dat_i = (idx == 2'd0) ? ($urandom_range(0, 7) & (($urandom_range(0, 7) == 0) ? 7 : 5))
                                         : $urandom;
                wb_cyc_i = 1; wb_stb_i = 1;
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          s0;
        wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 4'hF; wb_we_i = 0; wb_cyc_i = 0; wb_stb_i = 0;
        acc_in_ready = 0; acc_out_data = 0; acc_out_valid = 0; acc_done = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        checking = 1;

        wb_xfer(0, 32'h4, 0, rd, er);
        check_output("reset_status", rd, 32'h0000_0008);

        // Three writes drain straight into a ready accelerator.
        acc_in_ready = 1;
        wb_xfer(1, 32'h8, 32'h11, rd, er); check_output("push11_err", 32'(er), 0);
        wb_xfer(1, 32'h8, 32'h22, rd, er); check_output("push22_err", 32'(er), 0);
        wb_xfer(1, 32'h8, 32'h33, rd, er); check_output("push33_err", 32'(er), 0);
        wb_xfer(0, 32'h4, 0, rd, er);
        check_output("drained_status", rd, 32'h0000_0008);

        // Stalled accelerator: 16 fit, the 17th overflows; out FIFO is empty too.
        @(posedge clk); #2 acc_in_ready = 0;
        for (int i = 0; i < 17; i++) begin
            wb_xfer(1, 32'h8, 32'h100 + 32'(i), rd, er);
            check_output($sformatf("fill_err_%0d", i), 32'(er), 32'(i == 16));
        end
        wb_xfer(0, 32'h4, 0, rd, er);
        check_output("full_status", rd, 32'h0000_100C);
        wb_xfer(1, 32'h0, 32'h2, rd, er);
        check_output("clear_valid", 32'(acc_in_valid), 0);

        wb_xfer(0, 32'hC, 0, rd, er);
        check_output("empty_rd_err", 32'(er), 1);
        check_output("empty_rd_dat", rd, 0);
        @(posedge clk); #2 acc_out_valid = 1; acc_out_data = 32'hDEAD;
        @(posedge clk); #2 acc_out_valid = 0;
        wb_xfer(0, 32'hC, 0, rd, er);
        check_output("pop_err", 32'(er), 0);
        check_output("pop_dat", rd, 32'h0000_DEAD);
        wb_xfer(0, 32'h4, 0, rd, er);
        check_output("pop_status", rd, 32'h0000_0008);

        s0 = starts_seen;
        wb_xfer(1, 32'h0, 32'h1, rd, er);
        wb_xfer(0, 32'h4, 0, rd, er);
        check_output("busy_status", rd, 32'h0000_0009);
        pulse_done();
        wb_xfer(0, 32'h4, 0, rd, er);
        check_output("done_status", rd, 32'h0000_000A);
        pulse_done();
        wb_xfer(0, 32'h4, 0, rd, er);
        check_output("done2_status", rd, 32'h0000_000A);
        check_output("start_pulses", 32'(starts_seen - s0), 1);

        for (int i = 0; i < 5; i++)
            wb_xfer(1, 32'h8, 32'hA0 + 32'(i), rd, er);
        check_output("five_valid", 32'(acc_in_valid), 1);
        wb_xfer(1, 32'h0, 32'h2, rd, er);
        check_output("clear5_valid", 32'(acc_in_valid), 0);
        wb_xfer(0, 32'h4, 0, rd, er);
        check_output("clear5_status", rd, 32'h0000_000A);

        wb_xfer(1, 32'h4, 1, rd, er); check_output("wr_status_err", 32'(er), 1);
        wb_xfer(1, 32'hC, 1, rd, er); check_output("wr_dout_err", 32'(er), 1);
        wb_xfer(0, 32'h8, 0, rd, er); check_output("rd_din_err", 32'(er), 1);

        wb_xfer(1, 32'h0, 32'h4, rd, er);
        wb_xfer(0, 32'h0, 0, rd, er);
`ifdef ACCEL_SLAVE_IRQ_EN
        check_output("ctrl_rd", rd, 32'h4);
`else
        check_output("ctrl_rd", rd, 32'h0);
`endif

`ifdef ACCEL_SLAVE_IRQ_EN
        wb_xfer(1, 32'h0, 32'h5, rd, er);
        check_output("irq_busy", 32'(irq), 0);
        @(posedge clk); #2 acc_done = 1;
        @(posedge clk); #2 acc_done = 0;
        @(negedge clk);
        check_output("irq_same", 32'(irq), 0);
        @(negedge clk);
        check_output("irq_rise", 32'(irq), 1);
        wb_xfer(1, 32'h0, 32'h5, rd, er);
        @(negedge clk);
        check_output("irq_cleared", 32'(irq), 0);
        wb_xfer(1, 32'h0, 32'h0, rd, er);
`endif

        // Async reset lands while an ack is being driven.
        for (int i = 0; i < 3; i++)
            wb_xfer(1, 32'h8, 32'hC0 + 32'(i), rd, er);
        @(posedge clk); #2;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 32'h8; wb_dat_i = 32'h77;
        @(posedge clk); #2;
        check_output("pre_rst_ack", 32'(wb_ack_o), 1);
        #1 rst = 1;
        #1;
        check_output("rst_ack", 32'(wb_ack_o), 0);
        check_output("rst_valid", 32'(acc_in_valid), 0);
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        @(posedge clk); #2 rst = 0;
        wb_xfer(0, 32'h4, 0, rd, er);
        check_output("post_rst_status", rd, 32'h0000_0008);

        apply_stimulus(3000);
        @(posedge clk); #2;
        wb_cyc_i = 0; wb_stb_i = 0; acc_done = 0; acc_out_valid = 0;
        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
